// File: rtl/tblink_rpc_clkctrl_pkg.sv
// Command and status codes shared by the tblink controlled-clock controller.
package tblink_rpc_clkctrl_pkg;

  typedef enum logic [7:0] {
    CMD_GET_TIME    = 8'd1,
    CMD_SET_TIMER   = 8'd2,
    CMD_RELEASE     = 8'd3,
    CMD_SET_DIVISOR = 8'd4,
    CMD_HALT        = 8'd5
  } cmd_e;

  localparam logic [7:0] ST_OK          = 8'h00;
  localparam logic [7:0] ST_BAD_CHANNEL = 8'h01;
  localparam logic [7:0] ST_UNKNOWN     = 8'hFF;

endpackage

// File: rtl/tblink_rpc_clkdiv.sv
// One controlled-clock channel: period 2*(div+1) uclocks, registered output.
// Keeps counting while high even when disabled, so a halt never truncates a high phase.
module tblink_rpc_clkdiv #(
  parameter int DIV_W = 32
) (
  input  logic             uclock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             cclock_o,
  output logic             rise_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             active;
  logic             wrap;

  always_comb begin
    active = en_i || clk_q;
    wrap   = active && (cnt_q == div_q);
    clk_d  = wrap ? ~clk_q : clk_q;
    div_d  = wr_i ? div_i : div_q;
    if (wr_i || !active || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign cclock_o = clk_q;
  assign rise_o   = wrap && !clk_q;

endmodule

// File: rtl/tblink_rpc_clkctrl.sv
// Controlled-clock generator and time-keeper behind the cmd_in toggle handshake.
// Commands execute on the first edge they are pending; get toggles with 1-cycle latency.
module tblink_rpc_clkctrl
  import tblink_rpc_clkctrl_pkg::*;
#(
  parameter int N_CLOCKS         = 2,
  parameter int TIME_W           = 64,
  parameter int DIV_W            = 32,
  parameter int CMD_IN_PARAMS_SZ = 8,
  parameter int CMD_IN_RSP_SZ    = 8
) (
  input  logic                          uclock,
  input  logic                          reset,
  output logic [N_CLOCKS-1:0]           cclock,
  input  logic                          hreq_i,
  output logic                          hreq_o,
  input  logic [7:0]                    cmd_in,
  input  logic [7:0]                    cmd_in_sz,
  input  logic [8*CMD_IN_PARAMS_SZ-1:0] cmd_in_params,
  input  logic                          cmd_in_put_i,
  output logic                          cmd_in_get_i,
  output logic [8*CMD_IN_RSP_SZ-1:0]    cmd_in_rsp,
  output logic [7:0]                    cmd_in_rsp_sz
);

  logic                       run_q, run_d;
  logic                       armed_q, armed_d;
  logic                       hreq_q, hreq_d;
  logic                       get_q, get_d;
  logic [TIME_W-1:0]          count_q, count_d;
  logic [TIME_W-1:0]          target_q, target_d;
  logic [TIME_W-1:0]          count_inc;
  logic [8*CMD_IN_RSP_SZ-1:0] rsp_q, rsp_d;
  logic [7:0]                 rsp_sz_q, rsp_sz_d;
  logic [N_CLOCKS-1:0]        div_wr;
  logic [N_CLOCKS-1:0]        rise;
  logic [7:0]                 ch;
  logic [DIV_W-1:0]           div_val;
  logic                       pending, expire, en;
  logic                       unused_ok;

  assign en        = run_q && !hreq_i;
  assign pending   = cmd_in_put_i != get_q;
  assign ch        = cmd_in_params[7:0];
  assign div_val   = cmd_in_params[8 +: DIV_W];
  assign count_inc = count_q + 1'b1;
  // Equality against the wrapped sum keeps the compare correct across counter wrap.
  assign expire    = armed_q && rise[0] && (count_inc == target_q);
  assign unused_ok = ^{cmd_in_sz, cmd_in_params, rise};

  always_comb begin
    for (int k = 0; k < N_CLOCKS; k++) begin
      div_wr[k] = pending && (cmd_in == CMD_SET_DIVISOR) && (ch == 8'(k));
    end
  end

  always_comb begin
    run_d    = run_q;
    armed_d  = armed_q;
    hreq_d   = hreq_q;
    target_d = target_q;
    get_d    = get_q;
    rsp_d    = rsp_q;
    rsp_sz_d = rsp_sz_q;
    count_d  = rise[0] ? count_inc : count_q;
    if (expire) begin
      run_d   = 1'b0;
      armed_d = 1'b0;
      hreq_d  = 1'b1;
    end
    // Command writes come last so they win over a coincident expiry.
    if (pending) begin
      get_d    = cmd_in_put_i;
      rsp_d    = '0;
      rsp_sz_d = 8'd0;
      case (cmd_in)
        CMD_GET_TIME: begin
          rsp_d[TIME_W-1:0] = count_q;
          rsp_sz_d          = 8'd8;
        end
        CMD_SET_TIMER: begin
          target_d = count_q + cmd_in_params[TIME_W-1:0];
          armed_d  = 1'b1;
        end
        CMD_RELEASE: begin
          run_d  = 1'b1;
          hreq_d = 1'b0;
        end
        CMD_SET_DIVISOR: begin
          rsp_d[7:0] = (ch < 8'(N_CLOCKS)) ? ST_OK : ST_BAD_CHANNEL;
          rsp_sz_d   = 8'd1;
        end
        CMD_HALT: run_d = 1'b0;
        default: begin
          rsp_d[7:0] = ST_UNKNOWN;
          rsp_sz_d   = 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      armed_q  <= 1'b0;
      hreq_q   <= 1'b0;
      get_q    <= 1'b0;
      count_q  <= '0;
      target_q <= '0;
      rsp_q    <= '0;
      rsp_sz_q <= 8'd0;
    end else begin
      run_q    <= run_d;
      armed_q  <= armed_d;
      hreq_q   <= hreq_d;
      get_q    <= get_d;
      count_q  <= count_d;
      target_q <= target_d;
      rsp_q    <= rsp_d;
      rsp_sz_q <= rsp_sz_d;
    end
  end

  for (genvar k = 0; k < N_CLOCKS; k++) begin : g_ch
    tblink_rpc_clkdiv #(.DIV_W(DIV_W)) u_div (
      .uclock   (uclock),
      .reset    (reset),
      .en_i     (en),
      .wr_i     (div_wr[k]),
      .div_i    (div_val),
      .cclock_o (cclock[k]),
      .rise_o   (rise[k])
    );
  end

  assign hreq_o        = hreq_q;
  assign cmd_in_get_i  = get_q;
  assign cmd_in_rsp    = rsp_q;
  assign cmd_in_rsp_sz = rsp_sz_q;

endmodule

// File: tb/tb_tblink_rpc_clkctrl.sv
// Bench for tblink_rpc_clkctrl: directed scenarios plus random commands,
// checked every cycle against a period-position model of the clocks and time count.
module tb_tblink_rpc_clkctrl;

  localparam int     NC   = 2;
  localparam int     TW   = 8;
  localparam longint TMOD = 256;

  logic          uclock = 1'b0;
  logic          reset  = 1'b0;
  logic [NC-1:0] cclock;
  logic          hreq_i = 1'b0;
  logic          hreq_o;
  logic [7:0]    cmd_in = 8'd0;
  logic [7:0]    cmd_in_sz = 8'd0;
  logic [63:0]   cmd_in_params = 64'd0;
  logic          cmd_in_put_i = 1'b0;
  logic          cmd_in_get_i;
  logic [63:0]   cmd_in_rsp;
  logic [7:0]    cmd_in_rsp_sz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 uclock = ~uclock;

  tblink_rpc_clkctrl #(
    .N_CLOCKS(NC), .TIME_W(TW), .DIV_W(32), .CMD_IN_PARAMS_SZ(8), .CMD_IN_RSP_SZ(8)
  ) dut (
    .uclock        (uclock),
    .reset         (reset),
    .cclock        (cclock),
    .hreq_i        (hreq_i),
    .hreq_o        (hreq_o),
    .cmd_in        (cmd_in),
    .cmd_in_sz     (cmd_in_sz),
    .cmd_in_params (cmd_in_params),
    .cmd_in_put_i  (cmd_in_put_i),
    .cmd_in_get_i  (cmd_in_get_i),
    .cmd_in_rsp    (cmd_in_rsp),
    .cmd_in_rsp_sz (cmd_in_rsp_sz)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a position within its 2*(div+1) period;
  // the clock is high in the second half of the period.
  bit          m_run, m_armed, m_hreq, m_get;
  longint      m_count, m_target;
  longint      m_div [NC];
  longint      m_pos [NC];
  logic [63:0] m_rsp;
  int          m_sz;

  task automatic model_reset();
    m_run = 0; m_armed = 0; m_hreq = 0; m_get = 0;
    m_count = 0; m_target = 0; m_rsp = '0; m_sz = 0;
    for (int k = 0; k < NC; k++) begin
      m_div[k] = 0;
      m_pos[k] = 0;
    end
  endtask

  task automatic model_step();
    bit          en, rise0, expire;
    longint      old_count;
    logic [63:0] p;
    int          ch;
    en        = m_run && !hreq_i;
    rise0     = 0;
    old_count = m_count;
    for (int k = 0; k < NC; k++) begin
      bit act;
      act = en || (m_pos[k] > m_div[k]);
      if (k == 0 && act && m_pos[k] == m_div[k]) rise0 = 1;
      m_pos[k] = act ? (m_pos[k] + 1) % (2 * (m_div[k] + 1)) : 0;
    end
    if (rise0) m_count = (old_count + 1) % TMOD;
    expire = m_armed && rise0 && (((old_count + 1) % TMOD) == m_target);
    if (expire) begin
      m_run = 0; m_armed = 0; m_hreq = 1;
    end
    if (cmd_in_put_i != m_get) begin
      p     = cmd_in_params;
      m_get = cmd_in_put_i;
      m_rsp = '0;
      m_sz  = 0;
      case (cmd_in)
        8'd1: begin m_rsp = 64'(old_count); m_sz = 8; end
        8'd2: begin m_target = (old_count + longint'(p[7:0])) % TMOD; m_armed = 1; end
        8'd3: begin m_run = 1; m_hreq = 0; end
        8'd4: begin
          ch = int'(p[7:0]);
          if (ch < NC) begin
            bit hi;
            hi = m_pos[ch] > m_div[ch];
            m_div[ch] = longint'(p[39:8]);
            m_pos[ch] = hi ? m_div[ch] + 1 : 0;
            m_rsp = 64'h0;
          end else begin
            m_rsp = 64'h1;
          end
          m_sz = 1;
        end
        8'd5: m_run = 0;
        default: begin m_rsp = 64'hFF; m_sz = 1; end
      endcase
    end
  endtask

  task automatic model_check();
    logic [63:0] mask;
    for (int k = 0; k < NC; k++)
      chk($sformatf("cclock%0d", k), cclock[k], m_pos[k] > m_div[k]);
    chk("hreq_o", hreq_o, m_hreq);
    chk("get", cmd_in_get_i, m_get);
    chk("rsp_sz", cmd_in_rsp_sz, m_sz);
    mask = (m_sz >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((m_sz == 1) ? 64'hFF : 64'h0);
    chk("rsp", cmd_in_rsp & mask, m_rsp & mask);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge uclock or posedge reset);
      if (reset) model_reset();
      else model_step();
      #1;
      model_check();
    end
  end

  task automatic issue(input logic [7:0] code, input logic [63:0] p);
    @(negedge uclock);
    cmd_in        = code;
    cmd_in_params = p;
    cmd_in_sz     = 8'd8;
    cmd_in_put_i  = ~cmd_in_put_i;
    @(posedge uclock);
    #2;
  endtask

  task automatic do_reset();
    @(negedge uclock);
    reset        = 1'b1;
    cmd_in_put_i = 1'b0;
    hreq_i       = 1'b0;
    @(negedge uclock);
    reset = 1'b0;
  endtask

  // Cycles until cclock[ch] goes 0->1; -1 if it never does.
  task automatic wait_rise(input int ch, output int cyc);
    logic prev;
    cyc  = -1;
    prev = cclock[ch];
    for (int i = 1; i <= 100; i++) begin
      @(posedge uclock);
      #2;
      if (!prev && cclock[ch]) begin
        cyc = i;
        break;
      end
      prev = cclock[ch];
    end
  endtask

  // Counts cclock[0] rises until hreq_o rises, bounded by maxc cycles.
  task automatic wait_hreq(input int maxc, output int rises);
    logic prev;
    rises = 0;
    prev  = cclock[0];
    for (int i = 0; i < maxc; i++) begin
      @(posedge uclock);
      #2;
      if (cclock[0] && !prev) rises++;
      prev = cclock[0];
      if (hreq_o) break;
    end
  endtask

  initial begin
    int c, per, hi;
    #1 reset = 1'b1;
    #2;
    chk("rst_cclock", cclock, 0);
    chk("rst_hreq", hreq_o, 0);
    chk("rst_get", cmd_in_get_i, 0);
    chk("rst_rsp", cmd_in_rsp, 0);
    chk("rst_rsp_sz", cmd_in_rsp_sz, 0);
    @(negedge uclock);
    reset = 1'b0;

    // Divisors 0: both clocks period 2, ten rises before GetTime.
    issue(8'd3, 64'd0);
    repeat (19) @(posedge uclock);
    issue(8'd1, 64'd0);
    chk("gettime10", cmd_in_rsp, 64'd10);
    chk("gettime10_sz", cmd_in_rsp_sz, 8);
    wait_rise(0, c);
    wait_rise(0, per);
    chk("period0_div0", per, 2);

    // Divisor programming and per-channel period.
    issue(8'd5, 64'd0);
    repeat (4) @(posedge uclock);
    issue(8'd4, (64'd3 << 8) | 64'd1);
    chk("setdiv_ok", cmd_in_rsp[7:0], 8'h00);
    chk("setdiv_sz", cmd_in_rsp_sz, 1);
    issue(8'd4, (64'd7 << 8) | 64'd5);
    chk("setdiv_badch", cmd_in_rsp[7:0], 8'h01);
    issue(8'd3, 64'd0);
    wait_rise(1, c);
    wait_rise(1, per);
    chk("period1_div3", per, 8);
    wait_rise(0, c);
    wait_rise(0, per);
    chk("period0_unchanged", per, 2);

    // Halt during a high phase of channel 1: the full 4-cycle high phase completes.
    wait_rise(1, c);
    issue(8'd5, 64'd0);
    hi = 1;
    for (int i = 0; i < 20 && cclock[1]; i++) begin
      hi++;
      @(posedge uclock);
      #2;
    end
    chk("halt_high_len", hi, 4);
    repeat (20) @(posedge uclock);
    #2;
    chk("halt_stopped", cclock, 0);

    // hreq_i pauses the clocks without clearing run.
    issue(8'd3, 64'd0);
    repeat (5) @(posedge uclock);
    @(negedge uclock);
    hreq_i = 1'b1;
    repeat (12) @(posedge uclock);
    #2;
    chk("hreq_i_paused", cclock, 0);
    @(negedge uclock);
    hreq_i = 1'b0;
    wait_rise(0, c);
    chk("hreq_i_resume", c, 1);

    // SetTimer delta 4 from count 0.
    do_reset();
    issue(8'd2, 64'd4);
    issue(8'd3, 64'd0);
    wait_hreq(60, c);
    chk("timer_rises", c, 4);
    chk("timer_hreq", hreq_o, 1);
    repeat (5) @(posedge uclock);
    #2;
    chk("timer_stopped", cclock, 0);
    issue(8'd1, 64'd0);
    chk("timer_gettime", cmd_in_rsp, 64'd4);

    // Asynchronous reset right on an expiry edge (clock high, hreq high).
    issue(8'd2, 64'd2);
    issue(8'd3, 64'd0);
    wait_hreq(60, c);
    chk("pre_reset_clk0", cclock[0], 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_cclock", cclock, 0);
    chk("async_rst_hreq", hreq_o, 0);
    cmd_in_put_i = 1'b0;
    @(negedge uclock);
    reset = 1'b0;

    // Wrap: expire at 254, then delta 3 targets 1; Release lands on that expiry edge.
    issue(8'd2, 64'd254);
    issue(8'd3, 64'd0);
    wait_hreq(1200, c);
    chk("wrap_first_hreq", hreq_o, 1);
    issue(8'd1, 64'd0);
    chk("wrap_gettime254", cmd_in_rsp, 64'd254);
    issue(8'd2, 64'd3);
    issue(8'd3, 64'd0);
    repeat (4) @(posedge uclock);
    issue(8'd3, 64'd0);
    chk("wrap_release_hreq", hreq_o, 0);
    wait_rise(0, c);
    chk("wrap_keeps_running", c, 2);
    issue(8'd1, 64'd0);
    chk("wrap_gettime2", cmd_in_rsp, 64'd2);

    // Unknown command and handshake latency.
    @(negedge uclock);
    cmd_in       = 8'd9;
    cmd_in_put_i = ~cmd_in_put_i;
    #1;
    chk("unk_pending", cmd_in_get_i == cmd_in_put_i, 0);
    @(posedge uclock);
    #2;
    chk("unk_ack", cmd_in_get_i, cmd_in_put_i);
    chk("unk_rsp", cmd_in_rsp[7:0], 8'hFF);
    chk("unk_sz", cmd_in_rsp_sz, 1);

    // Random commands, hreq_i toggles and occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [63:0] p;
      int r;
      @(negedge uclock);
      reset = 1'b0;
      if ($urandom_range(0, 99) < 3) hreq_i = ~hreq_i;
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1;
      end else if (m_get == cmd_in_put_i && $urandom_range(0, 3) == 0) begin
        p = {$urandom, $urandom};
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: cmd_in = 8'd3;
          3:       cmd_in = 8'd5;
          4:       cmd_in = 8'd1;
          5, 6: begin
            cmd_in  = 8'd4;
            p[7:0]  = 8'($urandom_range(0, 3));
            p[39:8] = 32'($urandom_range(0, 4));
          end
          7, 8: begin
            cmd_in = 8'd2;
            p[7:0] = 8'($urandom_range(0, 12));
          end
          default: cmd_in = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(6, 255));
        endcase
        cmd_in_params = p;
        cmd_in_put_i  = ~cmd_in_put_i;
      end
    end
    @(negedge uclock);
    reset = 1'b0;
    repeat (5) @(posedge uclock);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
